// File: rtl/weight_tile_pingpong.sv
// Ping-pong weight tile buffer: one bank fills while the other is read.
// Latency: reads are combinational, and flags update on the edge that accepts or releases a beat.
// Backpressure: wr_ready stays low while the bank being written is still full.
module weight_tile_pingpong #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tile_ready,
  output logic [1:0]            bank_full,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  almost_full_pulse,
  output logic                  rd_underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] AF_FILL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];
  logic [CW-1:0]         wptr;
  logic [CW-1:0]         rcnt;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;

  assign wr_ready   = ~bank_full[wr_bank];
  assign tile_ready = bank_full[rd_bank];
  assign wr_fire    = wr_valid & wr_ready;
  assign rd_fire    = rd_en & tile_ready;

  // A filling bank is never full, so set and clear always target different banks.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (wr_fire && wptr == LAST) full_set = 2'b01 << wr_bank;
    if (rd_fire && rcnt == LAST) full_clr = 2'b01 << rd_bank;
  end

  always_comb begin
    rd_data = '0;
    if (rd_fire) rd_data = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

  // Storage carries no reset; clr only blocks the write.
  always_ff @(posedge clk) begin
    if (wr_fire && !clr) begin
      if (wr_bank) mem1[wptr[ADDR_WIDTH-1:0]] <= wr_data;
      else         mem0[wptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr              <= '0;
      rcnt              <= '0;
      wr_bank           <= 1'b0;
      rd_bank           <= 1'b0;
      bank_full         <= 2'b00;
      almost_full_pulse <= 1'b0;
      rd_underflow      <= 1'b0;
    end else if (clr) begin
      wptr              <= '0;
      rcnt              <= '0;
      wr_bank           <= 1'b0;
      rd_bank           <= 1'b0;
      bank_full         <= 2'b00;
      almost_full_pulse <= 1'b0;
      rd_underflow      <= 1'b0;
    end else begin
      almost_full_pulse <= wr_fire && ((wptr + ONE) == AF_FILL);
      bank_full         <= (bank_full | full_set) & ~full_clr;
      if (wr_fire) begin
        if (wptr == LAST) begin
          wptr    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wptr <= wptr + ONE;
        end
      end
      if (rd_fire) begin
        if (rcnt == LAST) begin
          rcnt    <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rcnt <= rcnt + ONE;
        end
      end
      if (rd_en && !tile_ready) rd_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_tile_pingpong.sv
// Bench for weight_tile_pingpong: a queue-of-tiles model checked every cycle, plus directed literal checks.
module tb_weight_tile_pingpong;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          tile_ready;
  logic [1:0]    bank_full;
  logic          wr_bank;
  logic          rd_bank;
  logic          almost_full_pulse;
  logic          rd_underflow;

  weight_tile_pingpong #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tile_ready(tile_ready), .bank_full(bank_full),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .almost_full_pulse(almost_full_pulse), .rd_underflow(rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: completed tiles queued in fill order; the front tile is the one being read.
  logic [DW-1:0] done_q[$];
  logic [DW-1:0] part_q[$];
  int            beats;
  bit            rel;
  bit            m_uf;
  bit            m_afp;
  int            m_ft;
  bit            m_wacc;
  bit            m_racc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      done_q.delete();
      part_q.delete();
      beats = 0;
      rel   = 1'b0;
      m_uf  = 1'b0;
      m_afp = 1'b0;
    end else begin
      m_ft   = done_q.size() / DEPTH;
      m_wacc = wr_valid && (m_ft < 2);
      m_racc = rd_en && (m_ft > 0);
      m_afp  = m_wacc && (part_q.size() + 1 == DEPTH - AFM);
      if (rd_en && m_ft == 0) m_uf = 1'b1;
      if (m_racc) begin
        beats++;
        if (beats == DEPTH) begin
          repeat (DEPTH) void'(done_q.pop_front());
          beats = 0;
          rel   = ~rel;
        end
      end
      if (m_wacc) begin
        part_q.push_back(wr_data);
        if (part_q.size() == DEPTH) begin
          foreach (part_q[i]) done_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
    end
  end

  int            c_ft;
  logic [1:0]    c_bf;
  logic [DW-1:0] c_rd;

  always @(negedge clk) begin
    c_ft = done_q.size() / DEPTH;
    c_bf = 2'b00;
    for (int k = 0; k < c_ft; k++) c_bf[(int'(rel) + k) % 2] = 1'b1;
    c_rd = (rd_en && c_ft > 0) ? done_q[rd_addr] : '0;
    chk("model_wr_ready", wr_ready, c_ft < 2);
    chk("model_tile_ready", tile_ready, c_ft > 0);
    chk("model_bank_full", bank_full, c_bf);
    chk("model_wr_bank", wr_bank, (int'(rel) + c_ft) % 2);
    chk("model_rd_bank", rd_bank, rel);
    chk("model_af_pulse", almost_full_pulse, m_afp);
    chk("model_underflow", rd_underflow, m_uf);
    chk("model_rd_data", rd_data, c_rd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [DW-1:0] base, input int n);
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + DW'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  localparam logic [DW-1:0] A = 32'hA000_0000;
  localparam logic [DW-1:0] B = 32'hB000_0000;
  localparam logic [DW-1:0] C = 32'hC000_0000;
  localparam logic [DW-1:0] D = 32'hD000_0000;
  localparam logic [DW-1:0] E = 32'hE000_0000;
  localparam logic [DW-1:0] F = 32'hF000_0000;
  localparam logic [DW-1:0] G = 32'h6000_0000;
  localparam logic [DW-1:0] H = 32'h7000_0000;

  initial begin
    int ord[4];
    ord = '{2, 0, 3, 1};
    rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    #3;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_tile_ready", tile_ready, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill bank 0 with A0..A3; pulse follows acceptance of A2.
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = A + DW'(i);
      tick();
      chk("a_af_pulse", almost_full_pulse, (i == 2));
    end
    wr_valid = 1'b0;
    chk("a_bank_full", bank_full, 2'b01);
    chk("a_wr_bank", wr_bank, 1);
    chk("a_tile_ready", tile_ready, 1);

    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_addr = AW'(3 - k);
      #1 chk("a_rd_data", rd_data, A + DW'(3 - k));
      tick();
    end
    rd_en = 1'b0;
    chk("a_drained_full", bank_full, 2'b00);
    chk("a_drained_rd_bank", rd_bank, 1);

    // Eight writes fill both banks; a ninth is refused.
    wr_burst(B, 8);
    chk("b_both_full", bank_full, 2'b11);
    chk("b_wr_ready_low", wr_ready, 0);
    chk("b_banks_equal", wr_bank, rd_bank);
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    chk("b_ninth_refused", bank_full, 2'b11);
    wr_valid = 1'b0;

    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_addr = AW'(k);
      if (k == 3) begin
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
      end
      #1 chk("b_rd_data", rd_data, B + DW'(k));
      if (k == 3) chk("b_release_cycle_wr_ready", wr_ready, 0);
      tick();
    end
    rd_en = 1'b0; wr_valid = 1'b0;
    chk("b_wr_ready_after", wr_ready, 1);
    chk("b_bank_full_after", bank_full, 2'b01);

    // Fill completes on the same edge that releases the other bank.
    wr_burst(C, 3);
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_addr = AW'(k);
      #1 chk("c_rd_bank0", rd_data, B + DW'(4 + k));
      tick();
    end
    wr_valid = 1'b1; wr_data = C + 32'd3; rd_addr = 2'd3;
    #1 chk("c_rd_last", rd_data, B + 32'd7);
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
    chk("c_simul_bank_full", bank_full, 2'b10);
    chk("c_simul_rd_bank", rd_bank, 1);
    chk("c_simul_wr_bank", wr_bank, 0);

    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_addr = AW'(ord[k]);
      #1 chk("c_rd_bank1", rd_data, C + DW'(ord[k]));
      tick();
    end
    rd_en = 1'b0;

    // Underflow: no data, no beat counted, sticky flag.
    rd_en = 1'b1; rd_addr = 2'd1;
    #1 chk("u_rd_data_zero", rd_data, 0);
    tick();
    rd_en = 1'b0;
    chk("u_flag_set", rd_underflow, 1);
    wr_burst(D, 4);
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_addr = AW'(k);
      tick();
    end
    chk("u_rcnt_unchanged", tile_ready, 1);
    rd_addr = 2'd3;
    tick();
    rd_en = 1'b0;
    chk("u_released", bank_full, 2'b00);
    chk("u_flag_sticky", rd_underflow, 1);

    // clr mid-fill, colliding with a write that would raise the pulse.
    wr_burst(E, 2);
    clr = 1'b1; wr_valid = 1'b1; wr_data = E + 32'd2;
    tick();
    clr = 1'b0; wr_valid = 1'b0;
    chk("clr_underflow", rd_underflow, 0);
    chk("clr_af_pulse", almost_full_pulse, 0);
    chk("clr_wr_bank", wr_bank, 0);
    chk("clr_bank_full", bank_full, 0);
    wr_burst(F, 3);
    chk("clr_wptr_zero_3", bank_full, 2'b00);
    wr_burst(F + 32'd3, 1);
    chk("clr_wptr_zero_4", bank_full, 2'b01);
    rd_en = 1'b1; rd_addr = 2'd0;
    #1 chk("clr_f0_index0", rd_data, F);
    rd_en = 1'b0;

    // Asynchronous reset mid-fill.
    wr_burst(G, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_bank_full", bank_full, 0);
    chk("arst_wr_bank", wr_bank, 0);
    chk("arst_wr_ready", wr_ready, 1);
    chk("arst_tile_ready", tile_ready, 0);
    rd_en = 1'b1;
    #1 chk("arst_rd_data", rd_data, 0);
    rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_burst(H, 3);
    chk("arst_3_writes", tile_ready, 0);
    wr_burst(H + 32'd3, 1);
    chk("arst_4_writes", tile_ready, 1);
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_addr = AW'(k);
      #1 chk("arst_rd_data_h", rd_data, H + DW'(k));
      tick();
    end
    rd_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/weight_tile_pingpong.md
WEIGHT_TILE_PINGPONG -- requirements
Module: weight_tile_pingpong

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the weight word width.
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the bank depth as DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter AF_MARGIN, default 1, SHALL set the almost-full threshold; legal range is 1..DEPTH-1.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 clr  in  1  synchronous soft clear.
REQ-007 wr_valid  in  1  write beat offered.
REQ-008 wr_ready  out  1  write beat can be accepted.
REQ-009 wr_data  in  DATA_WIDTH  write word.
REQ-010 rd_en  in  1  read beat request.
REQ-011 rd_addr  in  ADDR_WIDTH  read word index within the read bank.
REQ-012 rd_data  out  DATA_WIDTH  read word, combinational.
REQ-013 tile_ready  out  1  read bank holds a complete tile.
REQ-014 bank_full  out  2  per-bank full flags, bit b is bank b.
REQ-015 wr_bank, rd_bank  out  1 each  current write and read bank indices.
REQ-016 almost_full_pulse  out  1  one-cycle almost-full indication.
REQ-017 rd_underflow  out  1  sticky error flag.

Function
REQ-018 Storage SHALL be two banks, each of DEPTH x DATA_WIDTH (ping-pong); fill of one bank SHALL proceed while the other is being read.
REQ-019 wr_ready SHALL be the inverse of bank_full[wr_bank], combinationally.
REQ-020 A write SHALL be accepted only when wr_valid and wr_ready are both high.
  - An accepted beat SHALL store wr_data at bank wr_bank, index wptr.
  - wptr SHALL then increment by 1.
REQ-021 Acceptance of the beat at wptr == DEPTH-1 SHALL, on the same edge:
  - set bank_full[wr_bank];
  - clear wptr to 0;
  - toggle wr_bank.
REQ-022 tile_ready SHALL equal bank_full[rd_bank], combinationally.
REQ-023 rd_data SHALL be bank rd_bank, index rd_addr, when rd_en and tile_ready are both high; otherwise rd_data SHALL be all zeros.
  - No read latency.
  - rd_addr is user-driven and is independent of the internal beat count.
REQ-024 Each cycle with rd_en and tile_ready both high SHALL count one read beat in rcnt.
  - The DEPTH-th beat SHALL, on the same edge: clear bank_full[rd_bank], toggle rd_bank, and clear rcnt to 0.
REQ-025 rd_en while tile_ready is low SHALL NOT change rcnt. It SHALL set rd_underflow, which holds until clr or reset.
REQ-026 Completing a fill of one bank and releasing the other bank on the same edge SHALL both take effect.
REQ-027 No write SHALL occur to a full bank, even in the cycle it is released; the write SHALL be accepted from the next cycle.
REQ-028 almost_full_pulse SHALL be high for exactly one cycle, in the cycle after an accepted write that makes the fill count (wptr+1) equal DEPTH-AF_MARGIN. At no other time SHALL it be high.
REQ-029 When both banks are full:
  - wr_ready SHALL be low;
  - wr_bank SHALL equal rd_bank;
  - wr_data SHALL be ignored.
REQ-030 clr SHALL clear, on the next edge: wptr, rcnt, wr_bank, rd_bank, bank_full, almost_full_pulse and rd_underflow.
  - clr SHALL take priority over any write or read in the same cycle.
  - Memory contents SHALL NOT be cleared.
REQ-031 Internal counters SHALL be ADDR_WIDTH+1 bits wide and SHALL never wrap past DEPTH.

Reset
REQ-032 While rst_n is low, the following SHALL be 0 immediately, independent of clk: wptr, rcnt, wr_bank, rd_bank, bank_full, almost_full_pulse, rd_underflow.
  - As a result, wr_ready = 1, tile_ready = 0 and rd_data = 0.
REQ-033 Reset asserted mid-fill or mid-drain SHALL discard all partial progress. The first accepted write after release SHALL go to bank 0, index 0.
REQ-034 Memory contents SHALL NOT be reset.

Verification (DEPTH=4, AF_MARGIN=1, DATA_WIDTH=32)
REQ-035 Write A0..A3 back-to-back:
  - almost_full_pulse high one cycle, in the cycle after A2 is accepted;
  - bank_full=01, wr_bank=1, tile_ready=1.
REQ-036 Following REQ-035, assert rd_en with rd_addr 3,2,1,0:
  - rd_data = A3,A2,A1,A0;
  - after the 4th beat, bank_full=00 and rd_bank=1.
REQ-037 Write 8 words with no reads:
  - both banks full, wr_ready=0;
  - a 9th wr_valid is not accepted and bank contents are unchanged.
  Then drain bank 0: wr_ready=1 in the cycle after the 4th read beat.
REQ-038 Write B4 completing bank 1 on the same edge as the 4th read beat releasing bank 0 -> bank_full=10, rd_bank=1, wr_bank=0.
REQ-039 Assert rd_en with tile_ready=0 -> rd_data=0, rcnt unchanged, rd_underflow=1. Then pulse clr -> rd_underflow=0 and all pointers 0.
REQ-040 Assert rst_n low after 2 of 4 writes -> all flags immediately 0. The next write lands in bank 0, index 0; tile_ready=1 only after 4 new writes.
